// File: rtl/adder_bist.sv
// adder_bist: exhaustive built-in self-test sweep for a WIDTH-bit ripple adder.
// Drives every (a, b) pair, checks sum/carryout/overflow against a golden model,
// counts mismatches and captures the first failing operand pair.
module adder_bist #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [WIDTH-1:0]     a,
  output logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     sum,
  input  logic                 carryout,
  input  logic                 overflow,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH:0]     err_count,
  output logic [WIDTH-1:0]     fail_a,
  output logic [WIDTH-1:0]     fail_b
);

  localparam int unsigned IW = 2 * WIDTH;
  localparam int unsigned EW = 2 * WIDTH + 1;
  localparam int unsigned SW = WIDTH + 1;
  localparam int unsigned CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] a_d, b_d, fail_a_d, fail_b_d;
  logic            busy_d, done_d, pass_d;
  logic [EW-1:0]   err_d;

  logic [SW-1:0]    gold;
  logic [WIDTH-1:0] gold_s;
  logic             gold_c, gold_v, mism;
  logic             last_vec;

  // Golden model for the vector currently driven onto the adder; {a, b} is the sweep index.
  always_comb begin
    gold     = SW'(a) + SW'(b);
    gold_s   = gold[WIDTH-1:0];
    gold_c   = gold[WIDTH];
    gold_v   = (a[WIDTH-1] == b[WIDTH-1]) && (gold_s[WIDTH-1] != a[WIDTH-1]);
    mism     = (sum != gold_s) || (carryout != gold_c) || (overflow != gold_v);
    last_vec = ({a, b} == {IW{1'b1}});
  end

  // Next-state and next-output logic for the sweep controller.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a;
    b_d      = b;
    busy_d   = busy;
    done_d   = 1'b0;
    pass_d   = pass;
    err_d    = err_count;
    fail_a_d = fail_a;
    fail_b_d = fail_b;

    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          a_d      = '0;
          b_d      = '0;
          err_d    = '0;
          fail_a_d = '0;
          fail_b_d = '0;
          pass_d   = 1'b0;
          busy_d   = 1'b1;
          cnt_d    = CW'(SETTLE);
          state_d  = (SETTLE == 0) ? S_CHECK : S_SETTLE;
        end
      end

      S_SETTLE: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        if (mism) begin
          err_d = err_count + EW'(1);
          if (err_count == '0) begin
            fail_a_d = a;
            fail_b_d = b;
          end
        end
        if (last_vec) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          {a_d, b_d} = {a, b} + IW'(1);
          cnt_d      = CW'(SETTLE);
          state_d    = (SETTLE == 0) ? S_CHECK : S_SETTLE;
        end
      end

      S_DONE: begin
        pass_d  = (err_count == '0);
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      a         <= '0;
      b         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_a    <= '0;
      fail_b    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a         <= a_d;
      b         <= b_d;
      busy      <= busy_d;
      done      <= done_d;
      pass      <= pass_d;
      err_count <= err_d;
      fail_a    <= fail_a_d;
      fail_b    <= fail_b_d;
    end
  end

endmodule

// File: tb/tb_adder_bist.sv
// tb_adder_bist: scoreboard bench for adder_bist with a fault-injectable adder model.
module tb_adder_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start1, start0;
  logic [3:0] a1, b1, sum1, fa1, fb1;
  logic [3:0] a0, b0, sum0, fa0, fb0;
  logic       cout1, ovf1, busy1, done1, pass1;
  logic       cout0, ovf0, busy0, done0, pass0;
  logic [8:0] err1, err0;

  int          mode1 = 0, mode0 = 0;
  int unsigned seed1 = 0, seed0 = 0;
  int          checks = 0, errors = 0;
  int          cyc = 0;
  int          done_seen1 = 0, done_seen0 = 0;

  typedef struct {
    int err;
    int fa;
    int fb;
    int done_cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q0[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Adder under test: correct adder with optional injected fault.
  function automatic logic [5:0] adder_model(input int mode, input int unsigned seed,
                                             input logic [3:0] x, input logic [3:0] y);
    logic [4:0] t;
    logic       o;
    logic [5:0] r;
    logic [2:0] bi;
    t  = {1'b0, x} + {1'b0, y};
    o  = (x[3] == y[3]) && (t[3] != x[3]);
    r  = {o, t};
    bi = 3'(seed % 6);
    case (mode)
      1: r[4] = 1'b0;
      2: r[5] = 1'b0;
      3: r[0] = ~r[0];
      4: if ((((32'(x) * 16 + 32'(y)) * 5 + seed) % 13) == 0) r[bi] = ~r[bi];
      default: ;
    endcase
    return r;
  endfunction

  assign {ovf1, cout1, sum1} = adder_model(mode1, seed1, a1, b1);
  assign {ovf0, cout0, sum0} = adder_model(mode0, seed0, a0, b0);

  adder_bist #(.WIDTH(4), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .sum(sum1), .carryout(cout1), .overflow(ovf1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_a(fa1), .fail_b(fb1)
  );

  adder_bist #(.WIDTH(4), .SETTLE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0),
    .sum(sum0), .carryout(cout0), .overflow(ovf0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .fail_a(fa0), .fail_b(fb0)
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: walk all operand pairs using signed/unsigned integer arithmetic.
  task automatic ref_sweep(input int mode, input int unsigned seed,
                           output int cnt, output int fa, output int fb);
    logic [5:0] got;
    int sa, sb, gs, gc, gv;
    cnt = 0; fa = 0; fb = 0;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        got = adder_model(mode, seed, 4'(x), 4'(y));
        sa  = (x >= 8) ? x - 16 : x;
        sb  = (y >= 8) ? y - 16 : y;
        gs  = (x + y) % 16;
        gc  = (x + y >= 16) ? 1 : 0;
        gv  = (sa + sb > 7 || sa + sb < -8) ? 1 : 0;
        if (int'(got[3:0]) != gs || int'(got[4]) != gc || int'(got[5]) != gv) begin
          if (cnt == 0) begin
            fa = x;
            fb = y;
          end
          cnt++;
        end
      end
    end
  endtask

  // Monitor for the SETTLE=1 instance.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done1 === 1'b1) begin
        if (q1.size() == 0) begin
          chk("unexpected_done1", 1, 0);
        end else begin
          e = q1.pop_front();
          chk("err_count1", int'(err1), e.err);
          chk("fail_a1", int'(fa1), e.fa);
          chk("fail_b1", int'(fb1), e.fb);
          chk("done_cycle1", cyc, e.done_cyc);
          chk("busy_at_done1", int'(busy1), 0);
          @(negedge clk);
          chk("done_width1", int'(done1), 0);
          chk("pass1", int'(pass1), (e.err == 0) ? 1 : 0);
        end
        done_seen1++;
      end
    end
  end

  // Monitor for the SETTLE=0 instance.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done0 === 1'b1) begin
        if (q0.size() == 0) begin
          chk("unexpected_done0", 1, 0);
        end else begin
          e = q0.pop_front();
          chk("err_count0", int'(err0), e.err);
          chk("fail_a0", int'(fa0), e.fa);
          chk("fail_b0", int'(fb0), e.fb);
          chk("done_cycle0", cyc, e.done_cyc);
          chk("busy_at_done0", int'(busy0), 0);
          @(negedge clk);
          chk("done_width0", int'(done0), 0);
          chk("pass0", int'(pass0), (e.err == 0) ? 1 : 0);
        end
        done_seen0++;
      end
    end
  end

  task automatic chk_zero1(input string tag);
    chk({tag, "_a"}, int'(a1), 0);
    chk({tag, "_b"}, int'(b1), 0);
    chk({tag, "_busy"}, int'(busy1), 0);
    chk({tag, "_done"}, int'(done1), 0);
    chk({tag, "_pass"}, int'(pass1), 0);
    chk({tag, "_err"}, int'(err1), 0);
    chk({tag, "_fa"}, int'(fa1), 0);
    chk({tag, "_fb"}, int'(fb1), 0);
  endtask

  // One sweep on the selected instance; optional mid-sweep re-start or reset.
  task automatic run(input bit d0, input int mode, input int unsigned seed,
                     input int restart_at, input int reset_at);
    exp_t e;
    int cnt, fa, fb, target, k, per, seen;
    bit aborted;
    aborted = 1'b0;
    ref_sweep(mode, seed, cnt, fa, fb);
    per = d0 ? 1 : 2;
    @(negedge clk);
    if (d0) begin
      mode0 = mode; seed0 = seed; start0 = 1'b1; target = done_seen0 + 1;
    end else begin
      mode1 = mode; seed1 = seed; start1 = 1'b1; target = done_seen1 + 1;
    end
    @(posedge clk);
    #1;
    k = cyc;
    start0 = 1'b0;
    start1 = 1'b0;
    e.err = cnt; e.fa = fa; e.fb = fb; e.done_cyc = k + per * 256;
    if (d0) q0.push_back(e); else q1.push_back(e);
    chk("busy_after_start", int'(d0 ? busy0 : busy1), 1);
    chk("a_after_start", int'(d0 ? a0 : a1), 0);
    chk("b_after_start", int'(d0 ? b0 : b1), 0);
    chk("err_after_start", int'(d0 ? err0 : err1), 0);
    for (int i = 1; i <= per * 256 + 40; i++) begin
      @(negedge clk);
      if (!d0) start1 = (i == restart_at);
      if (reset_at > 0 && i == reset_at) rst_n = 1'b0;
      if (reset_at > 0 && i == reset_at + 1) begin
        rst_n = 1'b1;
        start1 = 1'b0;
        q1.delete();
        chk_zero1("after_reset");
        aborted = 1'b1;
        break;
      end
      seen = d0 ? done_seen0 : done_seen1;
      if (seen >= target) break;
    end
    start1 = 1'b0;
    if (aborted) begin
      repeat (600) @(negedge clk);
      chk("aborted_done_count", done_seen1, target - 1);
    end else begin
      seen = d0 ? done_seen0 : done_seen1;
      chk("sweep_completed", seen, target);
      repeat (3) @(negedge clk);
      chk("pass_held", int'(d0 ? pass0 : pass1), (cnt == 0) ? 1 : 0);
      chk("idle_after_done", int'(d0 ? busy0 : busy1), 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    start1 = 1'b0;
    start0 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero1("reset");
    chk("reset_busy0", int'(busy0), 0);
    chk("reset_err0", int'(err0), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run(1'b0, 0, 0, 0, 0);
    run(1'b0, 1, 0, 0, 0);
    run(1'b0, 2, 0, 0, 0);
    run(1'b0, 4, $urandom, 0, 0);
    run(1'b0, 4, $urandom, 0, 0);
    run(1'b0, 0, 0, 100, 0);
    run(1'b0, 0, 0, 0, 300);
    run(1'b0, 0, 0, 0, 0);
    run(1'b1, 3, 0, 0, 0);
    run(1'b1, 0, 0, 0, 0);
    run(1'b1, 4, $urandom, 0, 0);

    repeat (5) @(negedge clk);
    chk("queue1_drained", q1.size(), 0);
    chk("queue0_drained", q0.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
